// File: rtl/regfile_sb.sv
// 2-read/1-write register file with registered reads, optional zero register,
// selectable write-first bypass and a per-entry busy scoreboard.
module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              any_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  next_busy;
  logic              wr_eff;
  logic [DATA_W-1:0] rd_val_a;
  logic [DATA_W-1:0] rd_val_b;

  assign wr_eff = write_enable && !((ZERO_REG != 0) && (write_addr == '0));

  // Release happens before reserve so a same-edge reserve keeps the entry busy.
  always_comb begin
    next_busy = busy;
    if (write_enable) next_busy[write_addr] = 1'b0;
    if (reserve_en)   next_busy[reserve_addr] = 1'b1;
    if (ZERO_REG != 0) next_busy[0] = 1'b0;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if ((ZERO_REG != 0) && (addr == '0))
      return '0;
    else if ((BYPASS != 0) && wr_eff && (write_addr == addr))
      return write_data;
    else
      return regs[addr];
  endfunction

  always_comb begin
    rd_val_a = read_port(address_a);
    rd_val_b = read_port(address_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      data_a   <= '0;
      data_b   <= '0;
      busy_a   <= 1'b0;
      busy_b   <= 1'b0;
      any_busy <= 1'b0;
    end else begin
      if (wr_eff) regs[write_addr] <= write_data;
      busy     <= next_busy;
      any_busy <= |next_busy;
      if (rd_en) begin
        data_a <= rd_val_a;
        data_b <= rd_val_b;
        busy_a <= next_busy[address_a];
        busy_b <= next_busy[address_b];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three configurations driven in lockstep, checked every
// cycle against a behavioural model plus hand-computed directed expectations.
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd_en = 1'b0;
  logic [1:0] address_a = '0, address_b = '0;
  logic       write_enable = 1'b0;
  logic [1:0] write_addr = '0;
  logic [7:0] write_data = '0;
  logic       reserve_en = 1'b0;
  logic [1:0] reserve_addr = '0;

  // 0: ZERO_REG=0 BYPASS=1, 1: ZERO_REG=0 BYPASS=0, 2: ZERO_REG=1 BYPASS=1
  logic [7:0] da [3];
  logic [7:0] db [3];
  logic       ba [3];
  logic       bb [3];
  logic       anyb [3];

  int n_vec = 0;
  int n_bad = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .rd_en(rd_en), .address_a(address_a), .address_b(address_b),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .data_a(da[0]), .data_b(db[0]), .busy_a(ba[0]), .busy_b(bb[0]), .any_busy(anyb[0]));

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) u_old (
    .clk(clk), .reset(reset), .rd_en(rd_en), .address_a(address_a), .address_b(address_b),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .data_a(da[1]), .data_b(db[1]), .busy_a(ba[1]), .busy_b(bb[1]), .any_busy(anyb[1]));

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) u_zero (
    .clk(clk), .reset(reset), .rd_en(rd_en), .address_a(address_a), .address_b(address_b),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .data_a(da[2]), .data_b(db[2]), .busy_a(ba[2]), .busy_b(bb[2]), .any_busy(anyb[2]));

  // ---------------- behavioural model ----------------
  bit         zr [3] = '{1'b0, 1'b0, 1'b1};
  bit         bp [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] m_regs [3][4];
  bit         m_busy [3][4];
  logic [7:0] e_da [3], e_db [3];
  bit         e_ba [3], e_bb [3], e_any [3];

  function automatic logic [7:0] model_read(int c, logic [1:0] a);
    bit hit;
    hit = write_enable && (write_addr == a) && !(zr[c] && write_addr == 2'd0);
    if (zr[c] && a == 2'd0) return 8'h00;
    if (bp[c] && hit) return write_data;
    return m_regs[c][a];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 4; r++) begin
          m_regs[c][r] = 8'h00;
          m_busy[c][r] = 1'b0;
        end
        e_da[c] = 8'h00; e_db[c] = 8'h00;
        e_ba[c] = 1'b0;  e_bb[c] = 1'b0; e_any[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        bit nb [4];
        for (int r = 0; r < 4; r++) nb[r] = m_busy[c][r];
        if (write_enable) nb[write_addr] = 1'b0;
        if (reserve_en) nb[reserve_addr] = 1'b1;
        if (zr[c]) nb[0] = 1'b0;
        if (rd_en) begin
          e_da[c] = model_read(c, address_a);
          e_db[c] = model_read(c, address_b);
          e_ba[c] = nb[address_a];
          e_bb[c] = nb[address_b];
        end
        e_any[c] = nb[0] | nb[1] | nb[2] | nb[3];
        if (write_enable && !(zr[c] && write_addr == 2'd0))
          m_regs[c][write_addr] = write_data;
        for (int r = 0; r < 4; r++) m_busy[c][r] = nb[r];
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int c = 0; c < 3; c++) begin
        check($sformatf("model data_a[%0d]", c), 32'(da[c]), 32'(e_da[c]));
        check($sformatf("model data_b[%0d]", c), 32'(db[c]), 32'(e_db[c]));
        check($sformatf("model busy_a[%0d]", c), 32'(ba[c]), 32'(e_ba[c]));
        check($sformatf("model busy_b[%0d]", c), 32'(bb[c]), 32'(e_bb[c]));
        check($sformatf("model any_busy[%0d]", c), 32'(anyb[c]), 32'(e_any[c]));
      end
    end
  end

  // Apply inputs (called at a negedge), then return at the next negedge.
  task automatic step(bit rd, logic [1:0] aa, logic [1:0] ab,
                      bit we, logic [1:0] wa, logic [7:0] wd, bit re, logic [1:0] ra);
    rd_en = rd; address_a = aa; address_b = ab;
    write_enable = we; write_addr = wa; write_data = wd;
    reserve_en = re; reserve_addr = ra;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run = 1'b1;
    check("reset data_a", 32'(da[0]), 32'h0);
    check("reset any_busy", 32'(anyb[0]), 32'h0);

    // T1: preload, then asynchronous reset between edges
    step(1, 2'd0, 2'd0, 1, 2'd1, 8'h11, 0, 2'd0);
    step(1, 2'd0, 2'd0, 1, 2'd2, 8'h22, 1, 2'd3);
    step(1, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 2'd0);
    check("preload data_a", 32'(da[0]), 32'h11);
    check("preload data_b", 32'(db[0]), 32'h22);
    check("preload any_busy", 32'(anyb[0]), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async reset data_a", 32'(da[0]), 32'h0);
    check("async reset data_b", 32'(db[0]), 32'h0);
    check("async reset any_busy", 32'(anyb[0]), 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    step(1, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 2'd0);
    check("post-reset read a", 32'(da[0]), 32'h0);
    check("post-reset read b", 32'(db[0]), 32'h0);

    // T2: write then read
    step(1, 2'd0, 2'd0, 1, 2'd2, 8'hA5, 0, 2'd0);
    step(1, 2'd2, 2'd0, 0, 2'd0, 8'h00, 0, 2'd0);
    check("write-read data_a", 32'(da[0]), 32'hA5);

    // T3: same-edge write and read
    step(1, 2'd1, 2'd1, 1, 2'd1, 8'h3C, 0, 2'd0);
    check("bypass data_a", 32'(da[0]), 32'h3C);
    check("bypass data_b", 32'(db[0]), 32'h3C);
    check("read-old data_a", 32'(da[1]), 32'h00);
    check("read-old data_b", 32'(db[1]), 32'h00);
    step(1, 2'd1, 2'd1, 0, 2'd0, 8'h00, 0, 2'd0);
    check("read-old later data_a", 32'(da[1]), 32'h3C);

    // T4: zero register ignores writes and reserves
    step(1, 2'd0, 2'd0, 1, 2'd0, 8'hFF, 1, 2'd0);
    check("zero reg data_a", 32'(da[2]), 32'h0);
    check("zero reg busy_a", 32'(ba[2]), 32'h0);
    check("zero reg any_busy", 32'(anyb[2]), 32'h0);
    check("plain reg0 data_a", 32'(da[0]), 32'hFF);
    check("plain reg0 busy_a", 32'(ba[0]), 32'h1);
    step(1, 2'd0, 2'd0, 1, 2'd0, 8'h00, 0, 2'd0);

    // T5: scoreboard reserve/release
    step(1, 2'd3, 2'd0, 0, 2'd0, 8'h00, 1, 2'd3);
    check("reserve busy_a", 32'(ba[0]), 32'h1);
    check("reserve any_busy", 32'(anyb[0]), 32'h1);
    step(1, 2'd3, 2'd0, 1, 2'd3, 8'h5A, 1, 2'd3);
    check("write+reserve busy_a", 32'(ba[0]), 32'h1);
    check("write+reserve data_a", 32'(da[0]), 32'h5A);
    step(1, 2'd3, 2'd0, 1, 2'd3, 8'h77, 0, 2'd0);
    check("release busy_a", 32'(ba[0]), 32'h0);
    check("release data_a", 32'(da[0]), 32'h77);
    check("release any_busy", 32'(anyb[0]), 32'h0);
    check("release old data_a", 32'(da[1]), 32'h5A);

    // T6: rd_en=0 holds outputs while state keeps updating
    step(1, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 2'd0);
    step(0, 2'd3, 2'd0, 1, 2'd1, 8'hC1, 0, 2'd0);
    check("hold1 data_a", 32'(da[0]), 32'h3C);
    step(0, 2'd0, 2'd3, 1, 2'd2, 8'hC2, 0, 2'd0);
    check("hold2 data_b", 32'(db[0]), 32'hA5);
    step(0, 2'd2, 2'd1, 0, 2'd0, 8'h00, 1, 2'd1);
    check("hold3 data_a", 32'(da[0]), 32'h3C);
    check("hold3 busy_a", 32'(ba[0]), 32'h0);
    check("hold3 any_busy", 32'(anyb[0]), 32'h1);
    step(1, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 2'd0);
    check("resume data_a", 32'(da[0]), 32'hC1);
    check("resume data_b", 32'(db[0]), 32'hC2);
    check("resume busy_a", 32'(ba[0]), 32'h1);
    check("resume busy_b", 32'(bb[0]), 32'h0);

    step(1, 2'd0, 2'd1, 1, 2'd1, 8'h99, 0, 2'd0);
    step(1, 2'd1, 2'd3, 0, 2'd0, 8'h00, 0, 2'd0);
    check("final data_a", 32'(da[0]), 32'h99);
    check("final any_busy", 32'(anyb[0]), 32'h0);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
